mmio_peripheral: RTL and testbench



---
 rtl/mmio_pkg.sv | 41 ++++
 rtl/mmio_if.sv | 14 +
 rtl/mmio_timer.sv | 48 ++++
 rtl/mmio_peripheral.sv | 89 ++++++++
 tb/tb_mmio_peripheral.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripheral: register offsets,
// TCON bit positions, default window base and the offset decoder.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [7:0] TH_OFS      = 8'h00;
  localparam logic [7:0] TL_OFS      = 8'h04;
  localparam logic [7:0] TCON_OFS    = 8'h08;
  localparam logic [7:0] LED_OFS     = 8'h0C;
  localparam logic [7:0] DIGI_OFS    = 8'h10;
  localparam logic [7:0] SYSTICK_OFS = 8'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  typedef enum logic [2:0] {
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_DIGI,
    SEL_SYSTICK,
    SEL_NONE
  } reg_sel_e;

  // Decodes a word index (offset bits [7:2]); byte lanes never matter here.
  function automatic reg_sel_e decode_word(input logic [5:0] word);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word == TH_OFS[7:2])           sel = SEL_TH;
    else if (word == TL_OFS[7:2])      sel = SEL_TL;
    else if (word == TCON_OFS[7:2])    sel = SEL_TCON;
    else if (word == LED_OFS[7:2])     sel = SEL_LED;
    else if (word == DIGI_OFS[7:2])    sel = SEL_DIGI;
    else if (word == SYSTICK_OFS[7:2]) sel = SEL_SYSTICK;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_if.sv
// CPU data-memory port as seen by the peripheral window.
interface mmio_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        hit;

  modport master (output Address, Write_data, MemRead, MemWrite,
                  input  Read_data, hit);
  modport slave  (input  Address, Write_data, MemRead, MemWrite,
                  output Read_data, hit);
endinterface

// File: rtl/mmio_timer.sv
// Reloadable 32-bit timer: TH reload, TL counter, TCON enable/irq-enable/status,
// including the same-cycle priority between CPU writes and timer events.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon
);

  logic overflow;
  logic set_status;

  assign overflow   = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
  assign set_status = overflow && tcon[TCON_IE];

  // Reload reads the old TH, so a same-cycle TH write only affects later reloads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th)
        th <= wdata;

      if (wr_tl)
        tl <= wdata;
      else if (overflow)
        tl <= th;
      else if (tcon[TCON_EN])
        tl <= tl + 32'd1;

      // A timer-raised status cannot be lost to a software clear in the same cycle.
      if (wr_tcon)
        tcon <= {set_status | wdata[2], wdata[1:0]};
      else if (set_status)
        tcon[TCON_ST] <= 1'b1;
    end
  end

endmodule

// File: rtl/mmio_peripheral.sv
// Peripheral window beside DataMemory: timer, LED, 7-segment and cycle counter.
// Define MMIO_SYSTICK_EN to build the SYSTICK counter at offset 0x14.
module mmio_peripheral
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  mmio_if.slave       bus,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digi
);

  reg_sel_e    sel;
  logic        wr_en;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] rdata;
  logic        unused_byte_lane;

  assign unused_byte_lane = ^bus.Address[1:0];

  assign bus.hit = (bus.Address[31:8] == BASE_ADDR[31:8]);
  assign sel     = decode_word(bus.Address[7:2]);
  assign wr_en   = bus.MemWrite && bus.hit;

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr_en && (sel == SEL_TH)),
    .wr_tl   (wr_en && (sel == SEL_TL)),
    .wr_tcon (wr_en && (sel == SEL_TCON)),
    .wdata   (bus.Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon)
  );

  assign irq = tcon[TCON_ST] & tcon[TCON_IE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds <= '0;
      digi <= '0;
    end else if (wr_en) begin
      if (sel == SEL_LED)
        leds <= bus.Write_data[7:0];
      if (sel == SEL_DIGI)
        digi <= bus.Write_data[11:0];
    end
  end

`ifdef MMIO_SYSTICK_EN
  logic [31:0] systick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      systick <= '0;
    else
      systick <= systick + 32'd1;
  end
`endif

  // Zero unless a load hits a mapped register; matches DataMemory's 0-cycle read.
  always_comb begin
    rdata = '0;
    if (bus.MemRead && bus.hit) begin
      case (sel)
        SEL_TH:      rdata = th;
        SEL_TL:      rdata = tl;
        SEL_TCON:    rdata = {29'd0, tcon};
        SEL_LED:     rdata = {24'd0, leds};
        SEL_DIGI:    rdata = {20'd0, digi};
`ifdef MMIO_SYSTICK_EN
        SEL_SYSTICK: rdata = systick;
`else
        SEL_SYSTICK: rdata = '0;
`endif
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.Read_data = rdata;

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral against a cycle-level register model.
// Honours MMIO_SYSTICK_EN the same way as the design.
module tb_mmio_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digi;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_th, m_tl, m_systick;
  logic        m_en, m_ie, m_st;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  always #10 clk = ~clk;

  mmio_if bus ();

  mmio_peripheral dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq),
    .leds  (leds),
    .digi  (digi)
  );

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_systick = '0;
    m_en = 0; m_ie = 0; m_st = 0;
    m_led = '0; m_digi = '0;
  endtask

  // One clock of the register map, from the bus values present before the edge.
  task automatic model_step();
    logic [31:0] a, wd, n_th, n_tl;
    logic wr, set_st, n_en, n_ie, n_st;
    a = bus.Address; wd = bus.Write_data;
    wr = bus.MemWrite && (a[31:8] == BASE[31:8]);
    set_st = 0; n_th = m_th; n_tl = m_tl;
    if (m_en) begin
      if (m_tl == 32'hFFFF_FFFF) begin n_tl = m_th; set_st = m_ie; end
      else n_tl = m_tl + 1;
    end
    n_en = m_en; n_ie = m_ie; n_st = m_st | set_st;
    if (wr) begin
      case ({a[7:2], 2'b00})
        8'h00: n_th = wd;
        8'h04: n_tl = wd;
        8'h08: begin n_en = wd[0]; n_ie = wd[1]; n_st = set_st | wd[2]; end
        8'h0C: m_led = wd[7:0];
        8'h10: m_digi = wd[11:0];
        default: ;
      endcase
    end
    m_th = n_th; m_tl = n_tl; m_en = n_en; m_ie = n_ie; m_st = n_st;
    m_systick = m_systick + 1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    logic [31:0] r;
    r = '0;
    if (rd && a[31:8] == BASE[31:8]) begin
      case ({a[7:2], 2'b00})
        8'h00: r = m_th;
        8'h04: r = m_tl;
        8'h08: r = {29'd0, m_st, m_ie, m_en};
        8'h0C: r = {24'd0, m_led};
        8'h10: r = {20'd0, m_digi};
`ifdef MMIO_SYSTICK_EN
        8'h14: r = m_systick;
`endif
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    if (!reset) model_reset(); else model_step();
    @(posedge clk);
    @(negedge clk);
    bus.MemRead = 0; bus.MemWrite = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a; bus.Write_data = d; bus.MemWrite = 1; bus.MemRead = 0;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a; bus.MemRead = 1; bus.MemWrite = 0;
    #1 d = bus.Read_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) tick();
    reset = 1;
    bus_write(BASE + 32'h0C, 32'hFF);
    bus_write(BASE + 32'h10, 32'hFFF);
    bus_write(BASE + 32'h08, 32'h1);
    repeat (3) tick();
    #3 reset = 0;
    model_reset();
    #1;
    checks++; if (leds !== 8'h00) begin errors++; $display("[TB] FAIL reset_leds got=%h exp=00", leds); end
    checks++; if (digi !== 12'h000) begin errors++; $display("[TB] FAIL reset_digi got=%h exp=000", digi); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_tl_during got=%h exp=0", d); end
    @(negedge clk);
    reset = 1; bus.MemRead = 0;
    repeat (2) tick();
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_tl_after got=%h exp=0", d); end
  endtask

  task automatic test_reg_rw();
    logic [31:0] d;
    bus_write(BASE + 32'h0C, 32'h0000_01A5);
    bus_read(BASE + 32'h0C, d);
    checks++; if (d !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL led_read got=%h exp=000000a5", d); end
    checks++; if (leds !== 8'hA5) begin errors++; $display("[TB] FAIL led_out got=%h exp=a5", leds); end
    bus_write(BASE + 32'h12, 32'hFFFF_F123);
    bus_read(BASE + 32'h10, d);
    checks++; if (d !== 32'h0000_0123) begin errors++; $display("[TB] FAIL digi_read got=%h exp=00000123", d); end
    checks++; if (digi !== 12'h123) begin errors++; $display("[TB] FAIL digi_out got=%h exp=123", digi); end
    bus_write(BASE + 32'h40, 32'hDEAD_BEEF);
    bus_read(BASE + 32'h40, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read got=%h exp=0", d); end
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 32'(i * 4), d);
      checks++;
      if (d !== model_read(BASE + 32'(i * 4), 1'b1)) begin
        errors++; $display("[TB] FAIL unmapped_side_effect ofs=%0h got=%h exp=%h", i * 4, d, model_read(BASE + 32'(i * 4), 1'b1));
      end
    end
  endtask

  task automatic test_timer_reload();
    logic [31:0] d;
    bus_write(BASE + 32'h00, 32'hFFFF_FFF0);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h08, 32'h3);
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL reload_tl0 got=%h exp=fffffffe", d); end
    tick();
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reload_tl1 got=%h exp=ffffffff", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reload_irq_early got=%b exp=0", irq); end
    tick();
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'hFFFF_FFF0) begin errors++; $display("[TB] FAIL reload_tl2 got=%h exp=fffffff0", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL reload_irq got=%b exp=1", irq); end
    bus_write(BASE + 32'h08, 32'h3);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear got=%b exp=0", irq); end
    bus_read(BASE + 32'h08, d);
    checks++; if (d !== 32'h3) begin errors++; $display("[TB] FAIL tcon_after_clear got=%h exp=3", d); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
    tick();
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL simul_pre got=%h exp=ffffffff", d); end
    bus_write(BASE + 32'h04, 32'h5);
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'h5) begin errors++; $display("[TB] FAIL tl_write_wins got=%h exp=5", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL tl_write_irq got=%b exp=1", irq); end
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h08, 32'h3);
    bus_read(BASE + 32'h08, d);
    checks++; if (d !== 32'h7) begin errors++; $display("[TB] FAIL status_set_wins got=%h exp=7", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL status_set_irq got=%b exp=1", irq); end
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h00, 32'h0000_1234);
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'hFFFF_FFF0) begin errors++; $display("[TB] FAIL th_write_reload_old got=%h exp=fffffff0", d); end
    bus_read(BASE + 32'h00, d);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("[TB] FAIL th_write_new got=%h exp=00001234", d); end
  endtask

  task automatic test_enable_off();
    logic [31:0] d;
    bus_write(BASE + 32'h08, 32'h0);
    bus_write(BASE + 32'h04, 32'h7);
    repeat (10) tick();
    bus_read(BASE + 32'h04, d);
    checks++; if (d !== 32'h7) begin errors++; $display("[TB] FAIL enable_off_hold got=%h exp=7", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL enable_off_irq got=%b exp=0", irq); end
    bus_read(32'h1000_0000, d);
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("[TB] FAIL outside_hit got=%b exp=0", bus.hit); end
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL outside_read got=%h exp=0", d); end
    bus_read(BASE + 32'hFC, d);
    checks++; if (bus.hit !== 1'b1) begin errors++; $display("[TB] FAIL window_top_hit got=%b exp=1", bus.hit); end
  endtask

  task automatic test_systick();
    logic [31:0] a, b;
    bus_read(BASE + 32'h14, a);
    repeat (4) tick();
    bus_read(BASE + 32'h14, b);
`ifdef MMIO_SYSTICK_EN
    checks++; if (b - a !== 32'd4) begin errors++; $display("[TB] FAIL systick_delta got=%0d exp=4", b - a); end
    checks++; if (a !== m_systick - 32'd4) begin errors++; $display("[TB] FAIL systick_value got=%h exp=%h", a, m_systick - 32'd4); end
`else
    checks++; if (a !== 32'h0) begin errors++; $display("[TB] FAIL systick_off_a got=%h exp=0", a); end
    checks++; if (b !== 32'h0) begin errors++; $display("[TB] FAIL systick_off_b got=%h exp=0", b); end
`endif
    bus_write(BASE + 32'h14, 32'h1234_5678);
    bus_read(BASE + 32'h14, b);
    checks++; if (b !== model_read(BASE + 32'h14, 1'b1)) begin errors++; $display("[TB] FAIL systick_write_ignored got=%h exp=%h", b, model_read(BASE + 32'h14, 1'b1)); end
  endtask

  task automatic test_random();
    logic [31:0] a, exp_rd;
    int kind;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      a = BASE + 32'(kind * 4) + 32'($urandom_range(0, 3));
      else if (kind == 6) a = BASE + 32'($urandom_range(6, 63) * 4);
      else if (kind == 7) a = {8'h10, 24'($urandom)};
      else                a = BASE + 32'h04;
      bus.Address = a;
      bus.Write_data = (kind >= 8) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      bus.MemRead = 1'($urandom_range(0, 1));
      bus.MemWrite = 1'($urandom_range(0, 2) == 0);
      #1;
      exp_rd = model_read(a, bus.MemRead);
      checks++; if (bus.Read_data !== exp_rd) begin errors++; $display("[TB] FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, a, bus.Read_data, exp_rd); end
      checks++; if (bus.hit !== (a[31:8] == BASE[31:8])) begin errors++; $display("[TB] FAIL rand_hit n=%0d got=%b", n, bus.hit); end
      checks++; if (irq !== (m_st & m_ie)) begin errors++; $display("[TB] FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_st & m_ie); end
      checks++; if ({leds, digi} !== {m_led, m_digi}) begin errors++; $display("[TB] FAIL rand_outs n=%0d got=%h/%h exp=%h/%h", n, leds, digi, m_led, m_digi); end
      tick();
    end
  endtask

  initial begin
    bus.Address = '0; bus.Write_data = '0; bus.MemRead = 0; bus.MemWrite = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_reg_rw();
    test_timer_reload();
    test_simultaneous();
    test_enable_off();
    test_systick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
